// File: rtl/inport_ioc_bank.sv
// Port-mapped input bank: per-pin synchroniser, optional debounce, rising/falling
// interrupt-on-change with sticky flags, W1C clear and a global acknowledge.
module inport_ioc_bank #(
  parameter int unsigned WIDTH           = 8,
  parameter logic [7:0]  BASE_ADDR       = 8'h00,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic [7:0]       data_in,
  input  logic             wen,
  input  logic             ren,
  output logic [7:0]       data_out,
  output logic             rd_hit,
  input  logic [WIDTH-1:0] pins,
  output logic             int_out,
  input  logic             int_ack
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] s_last, stable, stable_prev_q;
  logic [WIDTH-1:0] pos_en_q, pos_en_d, neg_en_q, neg_en_d;
  logic [WIDTH-1:0] flags_q, flags_d, w1c, rise, fall;
  logic [7:0]       data_out_q, data_out_d, rd_word;
  logic             rd_hit_q, rd_hit_d;
  logic             hit;
  logic [1:0]       offset;

  // Upper data_in bits are don't-care when WIDTH < 8.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  assign hit    = (address[7:2] == BASE_ADDR[7:2]);
  assign offset = address[1:0];

  // Synchroniser chain: stage 0 samples the raw pins.
  always_comb begin
    sync_d[0] = pins;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];

  // Per-bit debounce; bypassed when DEBOUNCE_CYCLES is 0.
  if (DEBOUNCE_CYCLES == 0) begin : g_nodb
    assign stable = s_last;
  end else begin : g_db
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           stable_q, stable_d;

    // Accept a change only after it persists for DEBOUNCE_CYCLES cycles.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s_last[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          stable_d[i] = s_last[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        stable_q <= '0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable = stable_q;
  end

  // Edge detection gated by the enables as they stand now.
  assign rise = stable & ~stable_prev_q & pos_en_q;
  assign fall = ~stable & stable_prev_q & neg_en_q;

  // Register writes, W1C mask and flag update (set beats clear).
  always_comb begin
    pos_en_d = pos_en_q;
    neg_en_d = neg_en_q;
    w1c      = '0;
    if (wen && hit) begin
      case (offset)
        2'd1:    pos_en_d = data_in[WIDTH-1:0];
        2'd2:    neg_en_d = data_in[WIDTH-1:0];
        2'd3:    w1c      = data_in[WIDTH-1:0];
        default: ;
      endcase
    end
    flags_d = (rise | fall) | (flags_q & ~(w1c | {WIDTH{int_ack}}));
  end

  // Read mux and registered read port.
  always_comb begin
    rd_word = '0;
    case (offset)
      2'd0:    rd_word[WIDTH-1:0] = stable;
      2'd1:    rd_word[WIDTH-1:0] = pos_en_q;
      2'd2:    rd_word[WIDTH-1:0] = neg_en_q;
      default: rd_word[WIDTH-1:0] = flags_q;
    endcase
    data_out_d = data_out_q;
    rd_hit_d   = 1'b0;
    if (ren && hit) begin
      data_out_d = rd_word;
      rd_hit_d   = 1'b1;
    end
  end

  // Main state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      stable_prev_q <= '0;
      pos_en_q      <= '0;
      neg_en_q      <= '0;
      flags_q       <= '0;
      data_out_q    <= '0;
      rd_hit_q      <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stable_prev_q <= stable;
      pos_en_q      <= pos_en_d;
      neg_en_q      <= neg_en_d;
      flags_q       <= flags_d;
      data_out_q    <= data_out_d;
      rd_hit_q      <= rd_hit_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_hit   = rd_hit_q;
  assign int_out  = |flags_q;

endmodule

// File: tb/tb_inport_ioc_bank.sv
// Bench for inport_ioc_bank: three configurations (plain, debounced, narrow/offset base)
// driven by directed vectors; read responses are checked by a queue-based monitor.
module tb_inport_ioc_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address, data_in;
  logic [2:0] wen, ren, rd_hit, int_out;
  logic       int_ack;
  logic [7:0] dout [3];
  logic [7:0] pins0, pins1;
  logic [2:0] pins2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         d;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  inport_ioc_bank #(.WIDTH(8), .BASE_ADDR(8'h00), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wen(wen[0]), .ren(ren[0]),
    .data_out(dout[0]), .rd_hit(rd_hit[0]), .pins(pins0), .int_out(int_out[0]),
    .int_ack(int_ack)
  );

  inport_ioc_bank #(.WIDTH(8), .BASE_ADDR(8'h20), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wen(wen[1]), .ren(ren[1]),
    .data_out(dout[1]), .rd_hit(rd_hit[1]), .pins(pins1), .int_out(int_out[1]),
    .int_ack(int_ack)
  );

  inport_ioc_bank #(.WIDTH(3), .BASE_ADDR(8'h10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wen(wen[2]), .ren(ren[2]),
    .data_out(dout[2]), .rd_hit(rd_hit[2]), .pins(pins2), .int_out(int_out[2]),
    .int_ack(int_ack)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [7:0] v);
    address = a;
    data_in = v;
    wen[d]  = 1'b1;
    cyc(1);
    wen = '0;
  endtask

  task automatic rd(input int d, input logic [7:0] a, input logic [7:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb.push_back(e);
    address = a;
    ren[d]  = 1'b1;
    cyc(1);
    ren = '0;
  endtask

  // Monitor: every rd_hit pulse consumes the oldest expected read.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rd_hit[d]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rd_hit: inst %0d data %h expected no read", d, dout[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("read_inst%0d", e.d), {dout[d][7:0]}, e.v);
          if (e.d != d) chk("read_inst_id", 8'(d), 8'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; address = '0; data_in = '0; wen = '0; ren = '0; int_ack = 1'b0;
    pins0 = '0; pins1 = '0; pins2 = '0;
    cyc(3);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("reset_data_out", dout[d], 8'h00);
      chk("reset_rd_hit", {7'b0, rd_hit[d]}, 8'h00);
      chk("reset_int_out", {7'b0, int_out[d]}, 8'h00);
    end
    rd(0, 8'h00, 8'h00);

    // Rising edge on pin 3 with POS_EN bit 3
    wr(0, 8'h01, 8'h08);
    pins0[3] = 1'b1;
    cyc(2);
    chk("rise_int_early", {7'b0, int_out[0]}, 8'h00);
    cyc(1);
    chk("rise_int_set", {7'b0, int_out[0]}, 8'h01);
    rd(0, 8'h03, 8'h08);
    rd(0, 8'h00, 8'h08);
    rd(0, 8'h03, 8'h08);

    // Falling edge on pin 0, then W1C
    pins0[0] = 1'b1;
    cyc(4);
    wr(0, 8'h02, 8'h01);
    pins0[0] = 1'b0;
    cyc(4);
    rd(0, 8'h03, 8'h09);
    wr(0, 8'h03, 8'h01);
    rd(0, 8'h03, 8'h08);
    wr(0, 8'h03, 8'h08);
    chk("w1c_int_clear", {7'b0, int_out[0]}, 8'h00);
    rd(0, 8'h03, 8'h00);
    rd(0, 8'h01, 8'h08);
    rd(0, 8'h02, 8'h01);
    wr(0, 8'h00, 8'hFF);
    rd(0, 8'h00, 8'h08);
    wr(0, 8'h40, 8'hFF);
    rd(0, 8'h01, 8'h08);

    // int_ack coinciding with a new rise on bit 2
    wr(0, 8'h01, 8'h2C);
    pins0[5] = 1'b1;
    cyc(3);
    chk("bit5_int", {7'b0, int_out[0]}, 8'h01);
    pins0[2] = 1'b1;
    cyc(2);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    rd(0, 8'h03, 8'h04);

    // W1C on bit 5 coinciding with a new rise on bit 2
    pins0[2] = 1'b0;
    pins0[5] = 1'b0;
    cyc(3);
    wr(0, 8'h03, 8'h04);
    pins0[5] = 1'b1;
    cyc(3);
    rd(0, 8'h03, 8'h20);
    pins0[2] = 1'b1;
    cyc(2);
    wr(0, 8'h03, 8'h20);
    rd(0, 8'h03, 8'h04);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    chk("ack_int_clear", {7'b0, int_out[0]}, 8'h00);

    // Debounce: short glitch rejected, long pulse accepted
    wr(1, 8'h21, 8'h02);
    pins1[1] = 1'b1;
    cyc(3);
    pins1[1] = 1'b0;
    cyc(10);
    rd(1, 8'h20, 8'h00);
    rd(1, 8'h23, 8'h00);
    chk("glitch_int", {7'b0, int_out[1]}, 8'h00);
    pins1[1] = 1'b1;
    cyc(5);
    rd(1, 8'h20, 8'h00);
    pins1[1] = 1'b0;
    chk("db_int_early", {7'b0, int_out[1]}, 8'h00);
    rd(1, 8'h20, 8'h02);
    chk("db_int_set", {7'b0, int_out[1]}, 8'h01);
    rd(1, 8'h23, 8'h02);

    // Narrow bank at 0x10
    wr(2, 8'h11, 8'hFF);
    rd(2, 8'h11, 8'h07);
    address = 8'h14;
    ren[2]  = 1'b1;
    cyc(1);
    ren = '0;
    chk("oob_rd_hit", {7'b0, rd_hit[2]}, 8'h00);
    chk("oob_data_out", dout[2], 8'h07);
    wr(2, 8'h12, 8'hF8);
    rd(2, 8'h12, 8'h00);

    // Reset during an active debounce count with flags 0x81
    wr(1, 8'h21, 8'h81);
    wr(1, 8'h23, 8'hFF);
    pins1 = 8'h81;
    cyc(8);
    rd(1, 8'h23, 8'h81);
    pins1 = 8'h02;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    for (int d = 0; d < 3; d++) begin
      chk("midrst_data_out", dout[d], 8'h00);
      chk("midrst_rd_hit", {7'b0, rd_hit[d]}, 8'h00);
      chk("midrst_int_out", {7'b0, int_out[d]}, 8'h00);
    end
    rst = 1'b0;
    cyc(5);
    rd(1, 8'h20, 8'h00);
    rd(1, 8'h20, 8'h02);
    cyc(3);
    chk("post_rst_no_int", {7'b0, int_out[1]}, 8'h00);
    rd(1, 8'h23, 8'h00);
    rd(1, 8'h21, 8'h00);

    cyc(3);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_read: inst %0d no rd_hit, expected data %h", e.d, e.v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
